// File: rtl/regfile_vliw_pkg.sv
// Shared types and helpers for the multi-lane VLIW register file.
package regfile_vliw_pkg;

    typedef logic [4:0] regaddr_t;

    typedef enum logic {
        INIT,
        READY
    } rfstate_t;

    function automatic int numregs(input int e_supported);
        return (e_supported != 0) ? 16 : 32;
    endfunction

endpackage

// File: rtl/regfile_vliw_scoreboard.sv
// Per-register busy bits for long-latency producers; a set beats a clear of the same register.
module regfile_vliw_scoreboard
    import regfile_vliw_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int NUMREGS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [LANES-1:0]             sb_set,
    input  logic [LANES-1:0][4:0]        sb_addr,
    input  logic [LANES-1:0]             we,
    input  logic [LANES-1:0][4:0]        wa,
    input  logic [2*LANES-1:0][4:0]      ra,
    output logic [2*LANES-1:0]           rbusy
);
    localparam int AW = $clog2(NUMREGS);

    logic [NUMREGS-1:0] busy;
    logic [NUMREGS-1:0] busy_next;

    // Clears are applied first so that a same-cycle set on the same register wins.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < LANES; k++) begin
            if (we[k]) busy_next[wa[k][AW-1:0]] = 1'b0;
        end
        for (int k = 0; k < LANES; k++) begin
            if (sb_set[k]) busy_next[sb_addr[k][AW-1:0]] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else if (enable) begin
            busy <= busy_next;
        end
    end

    always_comb begin
        for (int i = 0; i < 2*LANES; i++) begin
            rbusy[i] = busy[ra[i][AW-1:0]];
        end
    end

endmodule

// File: rtl/regfile_vliw.sv
// Multi-lane VLIW register file with hardware clear sequencer and busy scoreboard.
// Define REGFILE_VLIW_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_vliw
    import regfile_vliw_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int E_SUPPORTED = 0,
    parameter int LANES       = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            ready,
    input  logic [2*LANES-1:0][4:0]         ra,
    output logic [2*LANES-1:0][XLEN-1:0]    rd,
    output logic [2*LANES-1:0]              rbusy,
    input  logic [LANES-1:0]                we,
    input  logic [LANES-1:0][4:0]           wa,
    input  logic [LANES-1:0][XLEN-1:0]      wd,
    input  logic [LANES-1:0]                sb_set,
    input  logic [LANES-1:0][4:0]           sb_addr,
    output logic                            wr_conflict
);
    localparam int NUMREGS = numregs(E_SUPPORTED);
    localparam int AW      = $clog2(NUMREGS);

    typedef logic [AW-1:0] idx_t;

    rfstate_t           state;
    idx_t               cnt;
    logic [XLEN-1:0]    rf [NUMREGS];
    logic [2*LANES-1:0] sb_busy;
    logic [2*LANES-1:0] fwd_hit;

    // The array has no reset; the sequencer zeroes x1..xN-1 one per cycle instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt   <= idx_t'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + idx_t'(1);
                    if (cnt == idx_t'(NUMREGS-1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Later lanes overwrite earlier ones, so the highest-index writer wins.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            rf[cnt] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (we[k] && wa[k][AW-1:0] != '0) rf[wa[k][AW-1:0]] <= wd[k];
            end
        end
    end

    always_comb begin
        wr_conflict = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (we[i] && we[j] && wa[i][AW-1:0] == wa[j][AW-1:0] && wa[i][AW-1:0] != '0)
                    wr_conflict = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2*LANES; i++) begin
            rd[i]      = '0;
            fwd_hit[i] = 1'b0;
            if (state == READY && ra[i][AW-1:0] != '0) begin
                rd[i] = rf[ra[i][AW-1:0]];
`ifdef REGFILE_VLIW_BYPASS_EN
                for (int k = 0; k < LANES; k++) begin
                    if (we[k] && wa[k][AW-1:0] == ra[i][AW-1:0]) begin
                        rd[i]      = wd[k];
                        fwd_hit[i] = 1'b1;
                    end
                end
`endif
            end
        end
    end

    regfile_vliw_scoreboard #(
        .LANES   (LANES),
        .NUMREGS (NUMREGS)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .enable  (state == READY),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .we      (we),
        .wa      (wa),
        .ra      (ra),
        .rbusy   (sb_busy)
    );

    assign rbusy = sb_busy & ~fwd_hit;

endmodule

// File: tb/tb_regfile_vliw.sv
// Self-checking bench for regfile_vliw: per-cycle model comparison plus directed literal checks.
module tb_regfile_vliw;
    localparam int XLEN  = 32;
    localparam int LANES = 4;
    localparam int NP    = 2*LANES;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       ready;
    logic [NP-1:0][4:0]         ra;
    logic [NP-1:0][XLEN-1:0]    rd;
    logic [NP-1:0]              rbusy;
    logic [LANES-1:0]           we;
    logic [LANES-1:0][4:0]      wa;
    logic [LANES-1:0][XLEN-1:0] wd;
    logic [LANES-1:0]           sb_set;
    logic [LANES-1:0][4:0]      sb_addr;
    logic                       wr_conflict;

    logic                       e_ready;
    logic [3:0][4:0]            e_ra;
    logic [3:0][XLEN-1:0]       e_rd;
    logic [3:0]                 e_rbusy;
    logic [1:0]                 e_we;
    logic [1:0][4:0]            e_wa;
    logic [1:0][XLEN-1:0]       e_wd;
    logic [1:0]                 e_sb_set;
    logic [1:0][4:0]            e_sb_addr;
    logic                       e_wr_conflict;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    logic [XLEN-1:0] mrf [32];
    bit              mbusy [32];
    bit              mready;
    int              mcount;

    regfile_vliw #(.XLEN(XLEN), .E_SUPPORTED(0), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .ready(ready), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
        .wr_conflict(wr_conflict)
    );

    regfile_vliw #(.XLEN(XLEN), .E_SUPPORTED(1), .LANES(2)) dut_e (
        .clk(clk), .reset(reset), .ready(e_ready), .ra(e_ra), .rd(e_rd), .rbusy(e_rbusy),
        .we(e_we), .wa(e_wa), .wd(e_wd), .sb_set(e_sb_set), .sb_addr(e_sb_addr),
        .wr_conflict(e_wr_conflict)
    );

    always #5 clk = ~clk;

    // Architectural model: reset makes every register read as zero, ready comes 31 edges later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin
                mrf[r]   = '0;
                mbusy[r] = 1'b0;
            end
            mready = 1'b0;
            mcount = 0;
        end else if (!mready) begin
            mcount++;
            if (mcount == 31) mready = 1'b1;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (we[k] && wa[k] != 5'd0) begin
                    mrf[wa[k]]   = wd[k];
                    mbusy[wa[k]] = 1'b0;
                end
            end
            for (int k = 0; k < LANES; k++) begin
                if (sb_set[k] && sb_addr[k] != 5'd0) mbusy[sb_addr[k]] = 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] expRd(input int i);
        logic [XLEN-1:0] v;
        if (!mready || ra[i] == 5'd0) return '0;
        v = mrf[ra[i]];
`ifdef REGFILE_VLIW_BYPASS_EN
        for (int k = 0; k < LANES; k++) if (we[k] && wa[k] == ra[i]) v = wd[k];
`endif
        return v;
    endfunction

    function automatic bit expBusy(input int i);
        bit b;
        if (!mready || ra[i] == 5'd0) return 1'b0;
        b = mbusy[ra[i]];
`ifdef REGFILE_VLIW_BYPASS_EN
        for (int k = 0; k < LANES; k++) if (we[k] && wa[k] == ra[i]) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit expConflict();
        for (int r = 1; r < 32; r++) begin
            int n = 0;
            for (int k = 0; k < LANES; k++) if (we[k] && wa[k] == 5'(r)) n++;
            if (n > 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge with write/set strobes idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        we       = '0;
        sb_set   = '0;
        e_we     = '0;
        e_sb_set = '0;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NP; i++) begin
                checkOutput($sformatf("rd[%0d]", i), rd[i], expRd(i));
                checkOutput($sformatf("rbusy[%0d]", i), XLEN'(rbusy[i]), XLEN'(expBusy(i)));
            end
            checkOutput("ready", XLEN'(ready), XLEN'(mready));
            checkOutput("wr_conflict", XLEN'(wr_conflict), XLEN'(expConflict()));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int initCycles;
        int eInitCycles;
        ra = '0; we = '0; wa = '0; wd = '0; sb_set = '0; sb_addr = '0;
        e_ra = '0; e_we = '0; e_wa = '0; e_wd = '0; e_sb_set = '0; e_sb_addr = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        #2;
        checkOutput("reset ready", XLEN'(ready), 0);
        checkOutput("reset rbusy", XLEN'(rbusy), 0);

        // Release reset; writes and sets during the clear must be ignored.
        reset = 1'b1;
        for (int i = 0; i < NP; i++) ra[i] = 5'(i + 3);
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h55;
        sb_set[1] = 1'b1; sb_addr[1] = 5'd5;
        initCycles = 0;
        eInitCycles = 0;
        for (int c = 0; c < 100 && !(ready && e_ready); c++) begin
            @(negedge clk);
            if (!ready) initCycles++;
            if (!e_ready) eInitCycles++;
            applyStimulus();
        end
        checkOutput("init cycles", initCycles, 31);
        checkOutput("e init cycles", eInitCycles, 15);
        ra[0] = 5'd5;
        #2;
        checkOutput("x5 after init", rd[0], 0);
        checkOutput("x5 busy after init", XLEN'(rbusy[0]), 0);

        applyStimulus();
        we = 4'hF;
        wa[0] = 5'd7; wa[1] = 5'd7; wa[2] = 5'd7; wa[3] = 5'd7;
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        #2;
        checkOutput("x7 conflict", XLEN'(wr_conflict), 1);
        applyStimulus();
        ra[0] = 5'd7;
        #2;
        checkOutput("x7 priority", rd[0], 32'h44);

        applyStimulus();
        we = 4'b0011; wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'h99; wd[1] = 32'h98;
        ra[1] = 5'd0;
        #2;
        checkOutput("x0 conflict", XLEN'(wr_conflict), 0);
        applyStimulus();
        we = 4'b1100; wa[2] = 5'd10; wa[3] = 5'd11; wd[2] = 32'h1010; wd[3] = 32'h1111;
        #2;
        checkOutput("x0 read", rd[1], 0);
        checkOutput("distinct conflict", XLEN'(wr_conflict), 0);
        applyStimulus();
        ra[5] = 5'd10; ra[6] = 5'd11;
        #2;
        checkOutput("x10 read", rd[5], 32'h1010);
        checkOutput("x11 read", rd[6], 32'h1111);

        applyStimulus();
        sb_set[2] = 1'b1; sb_addr[2] = 5'd9; ra[2] = 5'd9;
        #2;
        checkOutput("x9 busy pre", XLEN'(rbusy[2]), 0);
        applyStimulus();
        #2;
        checkOutput("x9 busy set", XLEN'(rbusy[2]), 1);
        applyStimulus();
        we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'hDEAD;
        sb_set[0] = 1'b1; sb_addr[0] = 5'd9;
        applyStimulus();
        #2;
        checkOutput("x9 set wins", XLEN'(rbusy[2]), 1);
        checkOutput("x9 data", rd[2], 32'hDEAD);
        applyStimulus();
        we[2] = 1'b1; wa[2] = 5'd9; wd[2] = 32'hBEEF;
        applyStimulus();
        #2;
        checkOutput("x9 busy cleared", XLEN'(rbusy[2]), 0);
        checkOutput("x9 new data", rd[2], 32'hBEEF);

        applyStimulus();
        we[3] = 1'b1; wa[3] = 5'd12; wd[3] = 32'h1234;
        applyStimulus();
        we[3] = 1'b1; wa[3] = 5'd12; wd[3] = 32'hCAFE;
        ra[0] = 5'd12;
        #2;
`ifdef REGFILE_VLIW_BYPASS_EN
        checkOutput("x12 same cycle", rd[0], 32'hCAFE);
`else
        checkOutput("x12 same cycle", rd[0], 32'h1234);
`endif
        applyStimulus();
        #2;
        checkOutput("x12 next cycle", rd[0], 32'hCAFE);

        applyStimulus();
        e_we[0] = 1'b1; e_wa[0] = 5'b10011; e_wd[0] = 32'h77;
        applyStimulus();
        e_ra[0] = 5'd3; e_ra[1] = 5'b10011;
        #2;
        checkOutput("e x3 read", e_rd[0], 32'h77);
        checkOutput("e alias read", e_rd[1], 32'h77);

        applyStimulus();
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5A5;
        sb_set[1] = 1'b1; sb_addr[1] = 5'd4;
        applyStimulus();
        ra[3] = 5'd4; ra[4] = 5'd3;
        #2;
        checkOutput("x4 busy", XLEN'(rbusy[3]), 1);
        checkOutput("x3 data", rd[4], 32'hA5A5);
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("midreset ready", XLEN'(ready), 0);
        checkOutput("midreset rbusy", XLEN'(rbusy[3]), 0);
        applyStimulus();
        reset = 1'b1;
        repeat (31) applyStimulus();
        #2;
        checkOutput("ready after reinit", XLEN'(ready), 1);
        checkOutput("x3 cleared", rd[4], 0);
        checkOutput("x4 not busy", XLEN'(rbusy[3]), 0);

        applyStimulus();
        @(negedge clk);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
